// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU: latches operands on accept, iterates
// one quotient bit per cycle, applies the sign fix-up and returns {remainder, quotient}.
module div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     rem_shift, trial;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               abort;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        // Magnitudes of the incoming operands; the most negative value maps to 2^(WIDTH-1).
        mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

        // One restoring step: a set top bit of trial means the subtraction borrowed.
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor_q};

        quo_fix = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;

        abort = annul_i || !start_i;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    divisor_d = mag2;
                    quo_d     = mag1;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
                    state_d   = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_END;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            S_ON: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q < CNT_W'(WIDTH)) begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = S_END;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end
            end
            S_END: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
